// File: rtl/mem_req_demux.sv
// Steers one upstream memory request to the data RAM (t0) or the MMIO window (t1) by address.
// Tracks the single outstanding request and returns its response, or an error response on timeout.
module mem_req_demux #(
    parameter int          N       = 32,
    parameter int          A       = 32,
    parameter logic [A-1:0] T1_BASE = 'h0000_1000,
    parameter logic [A-1:0] T1_MASK = 'hFFFF_F000,
    parameter int          TIMEOUT = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,

    input  logic           i_req_valid,
    output logic           o_req_ready,
    input  logic [A-1:0]   i_req_addr,
    input  logic           i_req_we,
    input  logic [N-1:0]   i_req_wdata,
    input  logic [N/8-1:0] i_req_be,

    output logic           o_resp_valid,
    output logic [N-1:0]   o_resp_rdata,
    output logic           o_resp_err,

    output logic           o_t0_req_valid,
    input  logic           i_t0_req_ready,
    output logic [A-1:0]   o_t0_addr,
    output logic           o_t0_we,
    output logic [N-1:0]   o_t0_wdata,
    output logic [N/8-1:0] o_t0_be,
    input  logic           i_t0_resp_valid,
    input  logic [N-1:0]   i_t0_rdata,

    output logic           o_t1_req_valid,
    input  logic           i_t1_req_ready,
    output logic [A-1:0]   o_t1_addr,
    output logic           o_t1_we,
    output logic [N-1:0]   o_t1_wdata,
    output logic [N/8-1:0] o_t1_be,
    input  logic           i_t1_resp_valid,
    input  logic [N-1:0]   i_t1_rdata
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT0,
        WAIT1
    } state_t;

    state_t         r_state;
    logic [TW-1:0]  r_timer;
    logic           r_we;
    logic           r_resp_valid;
    logic [N-1:0]   r_resp_rdata;
    logic           r_resp_err;

    logic           w_sel;
    logic           w_idle;
    logic           w_accept;
    logic           w_own_resp;
    logic [N-1:0]   w_own_rdata;

    assign w_sel  = ((i_req_addr & T1_MASK) == T1_BASE);
    assign w_idle = (r_state == IDLE);

    assign o_t0_req_valid = w_idle & i_req_valid & ~w_sel;
    assign o_t1_req_valid = w_idle & i_req_valid & w_sel;
    assign o_req_ready    = w_idle & (w_sel ? i_t1_req_ready : i_t0_req_ready);
    assign w_accept       = i_req_valid & o_req_ready;

    assign o_t0_addr  = i_req_addr;
    assign o_t0_we    = i_req_we;
    assign o_t0_wdata = i_req_wdata;
    assign o_t0_be    = i_req_be;
    assign o_t1_addr  = i_req_addr;
    assign o_t1_we    = i_req_we;
    assign o_t1_wdata = i_req_wdata;
    assign o_t1_be    = i_req_be;

    // Only the target that owns the outstanding request is listened to.
    assign w_own_resp  = (r_state == WAIT0) ? i_t0_resp_valid :
                         (r_state == WAIT1) ? i_t1_resp_valid : 1'b0;
    assign w_own_rdata = (r_state == WAIT1) ? i_t1_rdata : i_t0_rdata;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_timer      <= '0;
            r_we         <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= w_sel ? WAIT1 : WAIT0;
                        r_timer <= '0;
                        r_we    <= i_req_we;
                    end
                end
                WAIT0, WAIT1: begin
                    // A real response beats a timeout landing in the same cycle.
                    if (w_own_resp) begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_we ? '0 : w_own_rdata;
                        r_state      <= IDLE;
                        r_timer      <= '0;
                    end else if (r_timer == TW'(TIMEOUT - 1)) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_state      <= IDLE;
                        r_timer      <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_timer <= '0;
                end
            endcase
        end
    end

    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;

endmodule
